// File: rtl/space_wire_fifo_pkg.sv
// Shared helpers for the SpaceWire dual-clock FIFO: Gray conversion and
// synchroniser depth constants.
package space_wire_fifo_pkg;

  localparam int MIN_SYNC_STAGES = 2;
  localparam int RST_SYNC_STAGES = 2;
  localparam int GRAY_MAX_WIDTH  = 32;

  // Callers zero-extend narrower pointers, so any width up to 32 converts correctly.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
    logic [GRAY_MAX_WIDTH-1:0] bin;
    bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/space_wire_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer entering a new clock domain.
module space_wire_gray_sync #(
  parameter int WIDTH  = 7,
  parameter int STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] gray_out
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= gray_in;
      for (int i = 1; i < STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign gray_out = stage[STAGES-1];

endmodule

// File: rtl/space_wire_async_fifo.sv
// Dual-clock SpaceWire link FIFO with Gray-coded pointer crossing, exact full,
// threshold flags, overflow/underflow pulses and optional show-ahead read.
module space_wire_async_fifo
  import space_wire_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 9,
  parameter int ADDR_WIDTH   = 6,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_LEVEL  = 56,
  parameter int AEMPTY_LEVEL = 2,
  parameter int SHOW_AHEAD   = 0
) (
  input  logic                  i_wr_clk,
  input  logic                  i_reset_n,
  input  logic                  i_rd_clk,
  input  logic                  i_wren,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_afull,
  output logic [ADDR_WIDTH:0]   o_wrusdw,
  output logic                  o_overflow,
  input  logic                  i_rden,
  output logic [DATA_WIDTH-1:0] o_q,
  output logic                  o_empty,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_rdusdw,
  output logic                  o_underflow
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam int SYNC_N = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  localparam logic [PTR_W-1:0] DEPTH_V  = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AFULL_V  = PTR_W'(AFULL_LEVEL);
  localparam logic [PTR_W-1:0] AEMPTY_V = PTR_W'(AEMPTY_LEVEL);

  logic [RST_SYNC_STAGES-1:0] wr_rst_sync;
  logic [RST_SYNC_STAGES-1:0] rd_rst_sync;
  logic                       wr_rst_n;
  logic                       rd_rst_n;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, wr_ptr_next, wr_gray, wr_gray_sync, wr_ptr_sync, wr_used;
  logic [PTR_W-1:0] rd_ptr, rd_ptr_next, rd_gray, rd_gray_sync, rd_ptr_sync, rd_used;
  logic             wr_accept, rd_accept;
  logic             overflow_pulse, underflow_pulse;

  // Each domain leaves reset only after two of its own clock edges.
  always_ff @(posedge i_wr_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_rst_sync <= '0;
    end else begin
      wr_rst_sync <= {wr_rst_sync[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge i_rd_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_rst_sync <= '0;
    end else begin
      rd_rst_sync <= {rd_rst_sync[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign wr_rst_n = wr_rst_sync[RST_SYNC_STAGES-1];
  assign rd_rst_n = rd_rst_sync[RST_SYNC_STAGES-1];

  assign wr_used     = wr_ptr - rd_ptr_sync;
  assign o_full      = ~wr_rst_n | (wr_used == DEPTH_V);
  assign o_afull     = ~wr_rst_n | (wr_used >= AFULL_V);
  assign o_wrusdw    = wr_rst_n ? wr_used : '0;
  assign o_overflow  = overflow_pulse;
  assign wr_accept   = i_wren & ~o_full;
  assign wr_ptr_next = wr_ptr + PTR_W'(wr_accept);
  assign rd_ptr_sync = PTR_W'(gray2bin(GRAY_MAX_WIDTH'(rd_gray_sync)));

  // The Gray register tracks the next pointer so it changes on the same edge as the binary one.
  always_ff @(posedge i_wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr         <= '0;
      wr_gray        <= '0;
      overflow_pulse <= 1'b0;
    end else begin
      wr_ptr         <= wr_ptr_next;
      wr_gray        <= PTR_W'(bin2gray(GRAY_MAX_WIDTH'(wr_ptr_next)));
      overflow_pulse <= i_wren & o_full;
    end
  end

  always_ff @(posedge i_wr_clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= i_data;
    end
  end

  space_wire_gray_sync #(
    .WIDTH (PTR_W),
    .STAGES(SYNC_N)
  ) u_rd_to_wr_sync (
    .clock   (i_wr_clk),
    .reset_n (wr_rst_n),
    .gray_in (rd_gray),
    .gray_out(rd_gray_sync)
  );

  space_wire_gray_sync #(
    .WIDTH (PTR_W),
    .STAGES(SYNC_N)
  ) u_wr_to_rd_sync (
    .clock   (i_rd_clk),
    .reset_n (rd_rst_n),
    .gray_in (wr_gray),
    .gray_out(wr_gray_sync)
  );

  assign wr_ptr_sync = PTR_W'(gray2bin(GRAY_MAX_WIDTH'(wr_gray_sync)));
  assign rd_used     = wr_ptr_sync - rd_ptr;
  assign o_empty     = ~rd_rst_n | (rd_used == '0);
  assign o_aempty    = ~rd_rst_n | (rd_used <= AEMPTY_V);
  assign o_rdusdw    = rd_rst_n ? rd_used : '0;
  assign o_underflow = underflow_pulse;
  assign rd_accept   = i_rden & ~o_empty;
  assign rd_ptr_next = rd_ptr + PTR_W'(rd_accept);

  always_ff @(posedge i_rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr          <= '0;
      rd_gray         <= '0;
      underflow_pulse <= 1'b0;
    end else begin
      rd_ptr          <= rd_ptr_next;
      rd_gray         <= PTR_W'(bin2gray(GRAY_MAX_WIDTH'(rd_ptr_next)));
      underflow_pulse <= i_rden & o_empty;
    end
  end

  generate
    if (SHOW_AHEAD != 0) begin : g_show_ahead
      assign o_q = rd_rst_n ? mem[rd_ptr[ADDR_WIDTH-1:0]] : '0;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] q_reg;

      always_ff @(posedge i_rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
          q_reg <= '0;
        end else if (rd_accept) begin
          q_reg <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
      end

      assign o_q = q_reg;
    end
  endgenerate

endmodule

// File: tb/tb_space_wire_async_fifo.sv
// Self-checking bench for space_wire_async_fifo: directed corner cases on a
// default and a show-ahead instance, then a randomized run against a queue model.
module tb_space_wire_async_fifo;

  localparam int DEPTH = 64;

  logic       reset_n;
  logic       wr_clk;
  logic       rd_clk;
  int         wr_half = 5;
  int         rd_half = 5;

  logic       wren, rden;
  logic [8:0] data, q;
  logic       full, afull, overflow, empty, aempty, underflow;
  logic [6:0] wrusdw, rdusdw;

  logic        wren2, rden2;
  logic [15:0] data2, q2;
  logic        full2, afull2, overflow2, empty2, aempty2, underflow2;
  logic [4:0]  wrusdw2, rdusdw2;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int   writes;
    logic exp_afull;
    logic exp_full;
    int   exp_usdw;
  } fill_vec_t;

  fill_vec_t  fill_tab[5];
  logic [8:0] model_q[$];
  int         wr_done, rd_done;
  logic       rnd_we, rnd_re, exp_valid;
  logic [8:0] rnd_d, exp_word;
  int         rd_hi;

  space_wire_async_fifo dut (
    .i_wr_clk   (wr_clk),
    .i_reset_n  (reset_n),
    .i_rd_clk   (rd_clk),
    .i_wren     (wren),
    .i_data     (data),
    .o_full     (full),
    .o_afull    (afull),
    .o_wrusdw   (wrusdw),
    .o_overflow (overflow),
    .i_rden     (rden),
    .o_q        (q),
    .o_empty    (empty),
    .o_aempty   (aempty),
    .o_rdusdw   (rdusdw),
    .o_underflow(underflow)
  );

  space_wire_async_fifo #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (4),
    .AFULL_LEVEL(12),
    .SHOW_AHEAD (1)
  ) dut_sa (
    .i_wr_clk   (wr_clk),
    .i_reset_n  (reset_n),
    .i_rd_clk   (rd_clk),
    .i_wren     (wren2),
    .i_data     (data2),
    .o_full     (full2),
    .o_afull    (afull2),
    .o_wrusdw   (wrusdw2),
    .o_overflow (overflow2),
    .i_rden     (rden2),
    .o_q        (q2),
    .o_empty    (empty2),
    .o_aempty   (aempty2),
    .o_rdusdw   (rdusdw2),
    .o_underflow(underflow2)
  );

  // Read clock is phase-shifted so rd edges never coincide with wr edges in the directed part.
  initial begin
    wr_clk = 1'b0;
    forever #(wr_half) wr_clk = ~wr_clk;
  end

  initial begin
    rd_clk = 1'b0;
    #3;
    forever #(rd_half) rd_clk = ~rd_clk;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [8:0] d);
    wren = we;
    data = d;
    @(posedge wr_clk);
    #1;
    wren = 1'b0;
  endtask

  task automatic readCycle(input logic re);
    rden = re;
    @(posedge rd_clk);
    #1;
    rden = 1'b0;
  endtask

  initial begin
    fill_tab[0] = '{writes: 1,  exp_afull: 1'b0, exp_full: 1'b0, exp_usdw: 1};
    fill_tab[1] = '{writes: 55, exp_afull: 1'b0, exp_full: 1'b0, exp_usdw: 55};
    fill_tab[2] = '{writes: 56, exp_afull: 1'b1, exp_full: 1'b0, exp_usdw: 56};
    fill_tab[3] = '{writes: 63, exp_afull: 1'b1, exp_full: 1'b0, exp_usdw: 63};
    fill_tab[4] = '{writes: 64, exp_afull: 1'b1, exp_full: 1'b1, exp_usdw: 64};

    wren = 0; rden = 0; data = '0;
    wren2 = 0; rden2 = 0; data2 = '0;
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_full",   32'(full),   1);
    checkOutput("reset_afull",  32'(afull),  1);
    checkOutput("reset_empty",  32'(empty),  1);
    checkOutput("reset_aempty", 32'(aempty), 1);
    checkOutput("reset_wrusdw", 32'(wrusdw), 0);
    checkOutput("reset_q",      32'(q),      0);
    repeat (3) @(posedge wr_clk);
    #1;
    reset_n = 1'b1;
    repeat (4) @(posedge wr_clk);
    #1;
    checkOutput("release_full",  32'(full),  0);
    checkOutput("release_afull", 32'(afull), 0);
    checkOutput("release_empty", 32'(empty), 1);

    // A write must take exactly two rd edges to show up on the read side.
    wren = 1'b1; data = 9'h1A5;
    wren2 = 1'b1; data2 = 16'hBEEF;
    @(posedge wr_clk);
    #1;
    wren = 1'b0; wren2 = 1'b0;
    @(posedge rd_clk);
    #1;
    checkOutput("latency_empty_rd1", 32'(empty),  1);
    checkOutput("sa_empty_rd1",      32'(empty2), 1);
    @(posedge rd_clk);
    #1;
    checkOutput("latency_empty_rd2", 32'(empty),  0);
    checkOutput("latency_rdusdw",    32'(rdusdw), 1);
    checkOutput("latency_aempty",    32'(aempty), 1);
    checkOutput("sa_empty_rd2",      32'(empty2), 0);
    checkOutput("sa_q_before_read",  32'(q2),     32'hBEEF);
    rden = 1'b1; rden2 = 1'b1;
    @(posedge rd_clk);
    #1;
    rden = 1'b0; rden2 = 1'b0;
    checkOutput("first_read_q",      32'(q),      32'h1A5);
    checkOutput("first_read_empty",  32'(empty),  1);
    checkOutput("first_read_rdusdw", 32'(rdusdw), 0);
    checkOutput("sa_after_pop_empty", 32'(empty2), 1);

    @(posedge wr_clk);
    #1;
    repeat (3) @(posedge wr_clk);
    #1;
    checkOutput("drained_wrusdw", 32'(wrusdw), 0);

    for (int row = 0, written = 0; row < 5; row++) begin
      while (written < fill_tab[row].writes) begin
        applyStimulus(1'b1, 9'(written));
        written++;
      end
      checkOutput($sformatf("fill%0d_wrusdw", fill_tab[row].writes), 32'(wrusdw), 32'(fill_tab[row].exp_usdw));
      checkOutput($sformatf("fill%0d_afull",  fill_tab[row].writes), 32'(afull),  32'(fill_tab[row].exp_afull));
      checkOutput($sformatf("fill%0d_full",   fill_tab[row].writes), 32'(full),   32'(fill_tab[row].exp_full));
    end

    applyStimulus(1'b1, 9'h1FF);
    checkOutput("overflow_pulse",  32'(overflow), 1);
    checkOutput("overflow_wrusdw", 32'(wrusdw),   64);
    applyStimulus(1'b0, 9'h000);
    checkOutput("overflow_clear",  32'(overflow), 0);

    repeat (3) @(posedge rd_clk);
    #1;
    checkOutput("full_rdusdw", 32'(rdusdw), 64);
    checkOutput("full_aempty", 32'(aempty), 0);
    for (int i = 0; i < DEPTH; i++) begin
      readCycle(1'b1);
      checkOutput($sformatf("readback_%0d", i), 32'(q), 32'(i));
    end
    checkOutput("readback_empty",  32'(empty),  1);
    checkOutput("readback_rdusdw", 32'(rdusdw), 0);

    readCycle(1'b1);
    checkOutput("underflow_pulse",  32'(underflow), 1);
    checkOutput("underflow_q_held", 32'(q),         63);
    readCycle(1'b0);
    checkOutput("underflow_clear",  32'(underflow), 0);
    checkOutput("underflow_q_held2", 32'(q),        63);

    // Mid-operation reset with ten words stored, then a write attempted in the release window.
    @(posedge wr_clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 9'(9'h100 + 9'(i)));
    end
    repeat (3) @(posedge rd_clk);
    #1;
    checkOutput("pre_reset_rdusdw", 32'(rdusdw), 10);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_full",   32'(full),   1);
    checkOutput("midreset_empty",  32'(empty),  1);
    checkOutput("midreset_rdusdw", 32'(rdusdw), 0);
    checkOutput("midreset_q",      32'(q),      0);
    #20;
    @(posedge wr_clk);
    #1;
    reset_n = 1'b1;
    wren = 1'b1; data = 9'h077;
    @(posedge wr_clk);
    #1;
    checkOutput("release_window_full", 32'(full), 1);
    @(posedge wr_clk);
    #1;
    wren = 1'b0;
    checkOutput("postreset_full",     32'(full),     0);
    checkOutput("postreset_wrusdw",   32'(wrusdw),   0);
    checkOutput("postreset_overflow", 32'(overflow), 0);
    repeat (4) @(posedge rd_clk);
    #1;
    checkOutput("postreset_empty",  32'(empty),  1);
    checkOutput("postreset_rdusdw", 32'(rdusdw), 0);

    // Randomized traffic at a 3:7 clock ratio checked against an order-preserving queue.
    wr_half = 3;
    rd_half = 7;
    wr_done = 0;
    rd_done = 0;
    @(posedge wr_clk);
    #1;
    fork
      begin
        for (int c = 0; c < 4000 && wr_done < 200; c++) begin
          rnd_we = 1'($urandom_range(0, 1));
          rnd_d  = 9'($urandom);
          if (rnd_we && !full) begin
            model_q.push_back(rnd_d);
            wr_done++;
          end
          wren = rnd_we;
          data = rnd_d;
          @(posedge wr_clk);
          #1;
          checkRange("rand_wrusdw_bound", int'(wrusdw), model_q.size(), DEPTH);
        end
        wren = 1'b0;
      end
      begin
        for (int c = 0; c < 6000 && rd_done < 200; c++) begin
          rnd_re    = 1'($urandom_range(0, 1));
          exp_valid = 1'b0;
          if (rnd_re && !empty) begin
            if (model_q.size() == 0) begin
              checks++;
              errors++;
              $display("[TB] FAIL rand_phantom_word: actual=not empty required=empty");
            end else begin
              exp_word  = model_q.pop_front();
              exp_valid = 1'b1;
            end
            rd_done++;
          end
          rden = rnd_re;
          @(posedge rd_clk);
          #1;
          if (exp_valid) begin
            checkOutput("rand_q", 32'(q), 32'(exp_word));
          end
          rd_hi = (model_q.size() < DEPTH) ? model_q.size() : DEPTH;
          checkRange("rand_rdusdw_bound", int'(rdusdw), 0, rd_hi);
        end
        rden = 1'b0;
      end
    join
    checkOutput("rand_writes_done", 32'(wr_done), 200);
    checkOutput("rand_reads_done",  32'(rd_done), 200);
    checkOutput("rand_model_drained", 32'(model_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
